multiplier: RTL
===============

# multiplier

Iterative shift-and-add unsigned multiplier producing the low N bits of the product. It sits directly upstream of the shared Shifter: it issues shift jobs to it over the start/finished handshake and borrows the shared Adder and Comparator through operand/result ports rather than instantiating its own arithmetic. It gives the ALU a multiply operation built entirely from existing iterative units.

## Interface
- N, 4, operand, product and shifter data width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  reset; asynchronous assert, active-low (0 = reset)
- i_start  in  1  level request; operands sampled on the IDLE→CHECK transition
- o_finished  out  1  high in DONE; product valid
- i_multiplicand  in  N  operand A
- i_multiplier  in  N  operand B
- o_product  out  N  (A*B) mod 2^N
- o_shifter_start  out  1  shift request to Shifter
- i_shifter_finished  in  1  Shifter done
- o_shifter_direction  out  1  DIR_LEFT=0, DIR_RIGHT=1
- o_shifter_rotate  out  1  always 0 (logical shift)
- o_shifter_iterations  out  N  always 1 while requesting, else 0
- o_shifter_value  out  N  value to shift
- i_shifter_value  in  N  shifted result
- o_adder_augend, o_adder_addend  out  N  adder operands
- i_adder_sum  in  N  adder result (carry discarded)
- o_comparator_left, o_comparator_right  out  N  comparator operands
- i_comparator_equal  in  1  left == right

## Operation
- Registers: acc, a, b (N bits each), state.
- IDLE: if i_start=1 → a←multiplicand, b←multiplier, acc←0, go CHECK.
- CHECK: comparator left=b, right=0. equal → DONE; else b[0]=1 → ADD; else → SHIFT_A.
- ADD: augend=acc, addend=a; acc←i_adder_sum; → SHIFT_A (1 cycle).
- SHIFT_A: o_shifter_start=1, value=a, direction=DIR_LEFT, iterations=1. On i_shifter_finished=1: a←i_shifter_value, → WAIT_A.
- WAIT_A: start=0; stay until i_shifter_finished=0, then → SHIFT_B.
- SHIFT_B / WAIT_B: as SHIFT_A/WAIT_A with value=b, direction=DIR_RIGHT; on finish b←i_shifter_value; WAIT_B → CHECK.
- DONE: o_finished=1, o_product=acc. Stay while i_start=1; i_start=0 → IDLE (4-phase handshake, same convention as Shifter).
- Operand outputs to adder, comparator and shifter are 0 in every state that does not use them.
- Overflow: bits above N silently discarded (adder carry ignored, left shift drops MSB).
- Early exit on b==0 bounds the loop at N passes; multiplier=0 exits from first CHECK.
- Operand changes after IDLE are ignored until the next job.

## Timing
- Reset (i_reset=0, any state, including mid-shift): state←IDLE, acc/a/b←0, o_finished=0, o_product=0, o_shifter_start=0, all operand outputs 0. Shifter shares the reset, so no job is left dangling.
- o_product is the registered acc; it holds its last value in IDLE and is valid whenever o_finished=1.
- Latency from i_start to o_finished: 1 (IDLE) + per pass [1 CHECK + 1 if b[0] + 2×(shifter latency + 1 wait)] + 1 final CHECK.
- i_start held high through DONE does not restart; a new job requires i_start low for ≥1 cycle.
- i_shifter_finished seen outside SHIFT_x/WAIT_x is ignored.

## Structure
- Shared package turing_pkg: DIR_LEFT/DIR_RIGHT constants (also used by Shifter) and the multiplier state enum (IDLE, CHECK, ADD, SHIFT_A, WAIT_A, SHIFT_B, WAIT_B, DONE).
- No sub-module; one FSM plus datapath registers. Bench wrapper MultiplierTB instantiates Adder, Comparator, Shifter and multiplier, with optional WAVES dump to multiplier.vcd.

## Test plan
- N=4, A=3, B=5, start → o_finished=1, o_product=15; exactly 2 ADD states visited.
- A=7, B=0 → DONE after first CHECK, o_product=0, o_shifter_start never asserted.
- A=15, B=15 → o_product=1 (225 mod 16), 4 passes, acc wraps without error.
- A=0, B=9 → o_product=0; loop runs until b==0 (4 passes).
- Hold i_start high 10 cycles after o_finished → no restart, product stable; drop i_start → IDLE, o_finished=0 next cycle; new job A=2,B=6 → 12.
- Assert i_reset=0 during SHIFT_A of A=3,B=5 → all outputs 0 immediately; release and restart → 15.

Source files
------------

// File: rtl/turing_pkg.sv
// Shared definitions for the iterative arithmetic units: shift directions
// understood by the Shifter and the state encoding of the multiplier FSM.
package turing_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        SHIFT_A,
        WAIT_A,
        SHIFT_B,
        WAIT_B,
        DONE
    } mult_state_t;

endpackage

// File: rtl/multiplier.sv
// Iterative shift-and-add unsigned multiplier returning the low N bits of
// A*B. Owns no arithmetic: additions, zero tests and shifts are delegated
// to the shared Adder, Comparator and Shifter through the operand ports.
module multiplier
    import turing_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    output logic         o_finished,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic [N-1:0] o_product,
    output logic         o_shifter_start,
    input  logic         i_shifter_finished,
    output logic         o_shifter_direction,
    output logic         o_shifter_rotate,
    output logic [N-1:0] o_shifter_iterations,
    output logic [N-1:0] o_shifter_value,
    input  logic [N-1:0] i_shifter_value,
    output logic [N-1:0] o_adder_augend,
    output logic [N-1:0] o_adder_addend,
    input  logic [N-1:0] i_adder_sum,
    output logic [N-1:0] o_comparator_left,
    output logic [N-1:0] o_comparator_right,
    input  logic         i_comparator_equal
);

    mult_state_t state, state_next;
    logic [N-1:0] acc, acc_next;
    logic [N-1:0] a, a_next;
    logic [N-1:0] b, b_next;

    // The running accumulator is the product; it is only meaningful in DONE.
    assign o_product = acc;

    // State and datapath registers, cleared together so a reset mid-shift
    // leaves nothing half-updated.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            acc   <= '0;
            a     <= '0;
            b     <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            a     <= a_next;
            b     <= b_next;
        end
    end

    // Next-state, register updates and shared-unit operands; every unit sees
    // zero operands in states that do not use it.
    always_comb begin
        state_next           = state;
        acc_next             = acc;
        a_next               = a;
        b_next               = b;
        o_finished           = 1'b0;
        o_shifter_start      = 1'b0;
        o_shifter_direction  = DIR_LEFT;
        o_shifter_rotate     = 1'b0;
        o_shifter_iterations = '0;
        o_shifter_value      = '0;
        o_adder_augend       = '0;
        o_adder_addend       = '0;
        o_comparator_left    = '0;
        o_comparator_right   = '0;

        unique case (state)
            IDLE: begin
                if (i_start) begin
                    a_next     = i_multiplicand;
                    b_next     = i_multiplier;
                    acc_next   = '0;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                o_comparator_left  = b;
                o_comparator_right = '0;
                if (i_comparator_equal) begin
                    state_next = DONE;
                end else if (b[0]) begin
                    state_next = ADD;
                end else begin
                    state_next = SHIFT_A;
                end
            end
            ADD: begin
                o_adder_augend = acc;
                o_adder_addend = a;
                acc_next       = i_adder_sum;
                state_next     = SHIFT_A;
            end
            SHIFT_A: begin
                o_shifter_start      = 1'b1;
                o_shifter_value      = a;
                o_shifter_direction  = DIR_LEFT;
                o_shifter_iterations = N'(1);
                if (i_shifter_finished) begin
                    a_next     = i_shifter_value;
                    state_next = WAIT_A;
                end
            end
            WAIT_A: begin
                if (!i_shifter_finished) begin
                    state_next = SHIFT_B;
                end
            end
            SHIFT_B: begin
                o_shifter_start      = 1'b1;
                o_shifter_value      = b;
                o_shifter_direction  = DIR_RIGHT;
                o_shifter_iterations = N'(1);
                if (i_shifter_finished) begin
                    b_next     = i_shifter_value;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (!i_shifter_finished) begin
                    state_next = CHECK;
                end
            end
            DONE: begin
                o_finished = 1'b1;
                if (!i_start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
